adder_arbiter: RTL and testbench

- Shares one WIDTH-bit adder between NREQ requesters, such as PC+4, branch-target and address-calculation sources in multi-cycle or area-reduced variants of the core.
- Arbitration is round-robin; a valid/ready handshake applies on each request port.
- The sum is registered in a single-entry response buffer tagged with the requester index, and released to a consumer through its own valid/ready handshake.

---
 rtl/adder_arbiter.sv | 91 +++++++++
 tb/tb_adder_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: one shared WIDTH-bit adder serving NREQ requesters.
// Round-robin arbitration picks one request per cycle. Its sum and carry
// go into a single-entry response buffer that is tagged with the winner's
// index.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   req_valid[NREQ]    per-requester request strobe
//   req_a, req_b       packed operands; slice i belongs to requester i
//   req_ready[NREQ]    one-hot acceptance (combinational)
//   rsp_valid          response buffer holds a result
//   rsp_ready          consumer accepts the response
//   rsp_y, rsp_cout    registered sum and carry-out
//   rsp_id             index of the requester that produced rsp_y
module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id
);

  logic [IDW-1:0]   rr_ptr, g, idx;
  logic             any, accept, gnt;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   sum;

  // Rotating priority search: first valid at or after rr_ptr, wrapping.
  always_comb begin
    any = 1'b0;
    g   = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
  end

  // Operand mux feeding the single shared adder.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (g == IDW'(k)) begin
        a_sel = req_a[k*WIDTH +: WIDTH];
        b_sel = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sum = {1'b0, a_sel} + {1'b0, b_sel};

  // The buffer can take a new result when it is empty, or when it is
  // being drained on this same edge. Reset gates the grant so req_ready
  // stays low while rst_n is asserted.
  assign accept    = ~rsp_valid | rsp_ready;
  assign gnt       = rst_n & any & accept;
  assign req_ready = gnt ? (NREQ'(1) << g) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (gnt) begin
      // Loads while empty, or replaces a result consumed on this edge.
      rsp_valid           <= 1'b1;
      {rsp_cout, rsp_y}   <= sum;
      rsp_id              <= g;
      rr_ptr              <= (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter (WIDTH=8, NREQ=4). Directed scenarios from
// the test plan, then randomized traffic checked against a transaction-level
// reference model (pointer, buffer contents, integer sum).
module tb_adder_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0] req_ready;
  logic         rsp_valid, rsp_ready, rsp_cout;
  logic [W-1:0] rsp_y;
  logic [1:0]   rsp_id;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int       m_ptr;
  bit       m_valid;
  int       m_y, m_cout, m_id;
  logic [N-1:0] m_gnt;

  adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (!m_valid || rsp_ready)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req_valid[j] && r == '0) r[j] = 1'b1;
      end
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_y = 0; m_cout = 0; m_id = 0; m_gnt = '0;
  endtask

  // Advance the model with the current inputs, then clock the DUT.
  task automatic clk_edge();
    m_gnt = exp_ready();
    if (m_gnt != '0) begin
      for (int j = 0; j < N; j++)
        if (m_gnt[j]) begin
          int s;
          s = int'(req_a[j*W +: W]) + int'(req_b[j*W +: W]);
          m_y = s % 256; m_cout = (s > 255) ? 1 : 0; m_id = j;
          m_ptr = (j + 1) % N;
        end
      m_valid = 1;
    end else if (rsp_ready) m_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    n_chk++;
    if (req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_chk++;
    if ({rsp_valid, rsp_y, rsp_cout, rsp_id} !== '0) begin n_fail++;
      $display("FAIL reset_rsp: got v=%b y=%h c=%b id=%0d want all 0",
               rsp_valid, rsp_y, rsp_cout, rsp_id); end
    req_valid = '0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic_add();
    req_valid = 4'b0100; set_op(2, 'hCA, 'h35); rsp_ready = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0100) begin n_fail++;
      $display("FAIL basic_ready: got %b want 0100", req_ready); end
    clk_edge();
    req_valid = '0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_y !== 8'hFF || rsp_cout !== 1'b0 || rsp_id !== 2'd2) begin
      n_fail++;
      $display("FAIL basic_rsp: got v=%b y=%h c=%b id=%0d want v=1 y=ff c=0 id=2",
               rsp_valid, rsp_y, rsp_cout, rsp_id); end
    clk_edge();
  endtask

  task automatic test_carry();
    int av[2] = '{'hFF, 'h80};
    int bv[2] = '{'h01, 'h80};
    rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      req_valid = 4'b0001; set_op(0, av[t], bv[t]);
      #1;
      clk_edge();
      req_valid = '0;
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_y !== 8'h00 || rsp_cout !== 1'b1 || rsp_id !== 2'd0) begin
        n_fail++;
        $display("FAIL carry_%0d: got v=%b y=%h c=%b id=%0d want v=1 y=00 c=1 id=0",
                 t, rsp_valid, rsp_y, rsp_cout, rsp_id); end
    end
    clk_edge();
  endtask

  task automatic test_round_robin();
    test_reset();
    for (int i = 0; i < N; i++) set_op(i, 16 * i + 3, i + 1);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_chk++;
      if (req_ready !== (4'b0001 << (c % N))) begin n_fail++;
        $display("FAIL rr_grant_%0d: got %b want %b", c, req_ready, 4'b0001 << (c % N)); end
      n_chk++;
      if ($countones(req_ready) > 1) begin n_fail++;
        $display("FAIL rr_onehot_%0d: got %b want at most one bit", c, req_ready); end
      clk_edge();
      n_chk++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != c % N || int'(rsp_y) != 17 * (c % N) + 4) begin
        n_fail++;
        $display("FAIL rr_rsp_%0d: got v=%b id=%0d y=%0d want v=1 id=%0d y=%0d",
                 c, rsp_valid, rsp_id, rsp_y, c % N, 17 * (c % N) + 4); end
    end
    req_valid = '0;
    clk_edge();
  endtask

  task automatic test_backpressure();
    test_reset();
    set_op(1, 10, 20); set_op(3, 100, 200);
    req_valid = 4'b0010; rsp_ready = 1'b0;
    clk_edge();
    req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (req_ready !== 4'b0000) begin n_fail++;
        $display("FAIL bp_ready_%0d: got %b want 0000", c, req_ready); end
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 8'd30 || rsp_cout !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b id=%0d y=%0d want v=1 id=1 y=30",
                 c, rsp_valid, rsp_id, rsp_y); end
      clk_edge();
    end
    rsp_ready = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b1000) begin n_fail++;
      $display("FAIL bp_release: got %b want 1000", req_ready); end
    clk_edge();
    req_valid = '0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== 8'd44 || rsp_cout !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_next: got v=%b id=%0d y=%0d c=%b want v=1 id=3 y=44 c=1",
               rsp_valid, rsp_id, rsp_y, rsp_cout); end
    clk_edge();
  endtask

  task automatic test_skip_idle();
    test_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001; set_op(0, 1, 1); set_op(3, 2, 2);
    clk_edge();                     // pointer now 1
    req_valid = 4'b1001;
    #1;
    n_chk++;
    if (req_ready !== 4'b1000) begin n_fail++;
      $display("FAIL skip_first: got %b want 1000", req_ready); end
    clk_edge();
    n_chk++;
    if (req_ready !== 4'b0001) begin n_fail++;
      $display("FAIL skip_second: got %b want 0001", req_ready); end
    clk_edge();                     // pointer now 1 again
    req_valid = 4'b1111;
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) begin n_fail++;
      $display("FAIL skip_ptr: got %b want 0010", req_ready); end
    req_valid = '0;
    clk_edge();
  endtask

  task automatic test_async_reset();
    test_reset();
    req_valid = 4'b0001; set_op(0, 5, 6); set_op(2, 7, 8); rsp_ready = 1'b0;
    clk_edge();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL async_drop: got v=%b want 0", rsp_valid); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    req_valid = 4'b0100;
    #1;
    n_chk++;
    if (req_ready !== 4'b0100) begin n_fail++;
      $display("FAIL async_regrant: got %b want 0100", req_ready); end
    clk_edge();
    req_valid = '0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 8'd15) begin n_fail++;
      $display("FAIL async_rsp: got v=%b id=%0d y=%0d want v=1 id=2 y=15",
               rsp_valid, rsp_id, rsp_y); end
    clk_edge();
  endtask

  task automatic test_random();
    test_reset();
    for (int c = 0; c < 400; c++) begin
      // Requesters keep a pending request stable; new ones get fresh data.
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !m_gnt[i] && c > 0) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_chk++;
      if (req_ready !== exp_ready()) begin n_fail++;
        $display("FAIL rand_ready_%0d: got %b want %b", c, req_ready, exp_ready()); end
      clk_edge();
      n_chk++;
      if (rsp_valid !== m_valid ||
          (m_valid && (int'(rsp_y) != m_y || int'(rsp_cout) != m_cout || int'(rsp_id) != m_id)))
      begin n_fail++;
        $display("FAIL rand_rsp_%0d: got v=%b y=%0d c=%b id=%0d want v=%0d y=%0d c=%0d id=%0d",
                 c, rsp_valid, rsp_y, rsp_cout, rsp_id, m_valid, m_y, m_cout, m_id); end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_skip_idle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
